// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction memory arbiter between core fetch and loader with halt handshake
//
// Purpose: shares one synchronous single-port instruction memory between the
// core fetch port and a loader port. Fetch has priority, but a loader that has
// been refused STARVE_MAX times in a row is forced through. The loader can ask
// fetch to stop (halt_req). Once outstanding fetch responses are drained, it
// then owns the memory and halt_ack is asserted.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   f_req_*  / f_rsp_*                fetch request (valid/addr/ready) and response (valid/data/err)
//   l_req_*  / l_rsp_*                loader request (valid/we/addr/wdata/ready) and response
//   halt_req / halt_ack               loader stop request, registered acknowledge
//   mem_en/we/addr/wdata, mem_rdata   synchronous memory, read data one cycle after mem_en
module imem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req_valid,
    input  logic [31:0]       f_req_addr,
    output logic              f_req_ready,
    output logic              f_rsp_valid,
    output logic [31:0]       f_rsp_data,
    output logic              f_rsp_err,
    input  logic              l_req_valid,
    input  logic              l_req_we,
    input  logic [31:0]       l_req_addr,
    input  logic [31:0]       l_req_wdata,
    output logic              l_req_ready,
    output logic              l_rsp_valid,
    output logic [31:0]       l_rsp_data,
    output logic              l_rsp_err,
    input  logic              halt_req,
    output logic              halt_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_starve;
    logic             r_halt_ack;

    logic r_f_rsp_valid, r_f_rsp_err, r_f_rd;
    logic r_l_rsp_valid, r_l_rsp_err, r_l_rd;

    logic w_f_legal, w_l_legal, w_starved;
    logic w_f_grant, w_l_grant;

    // Word aligned and no bit set above the memory's byte-address range.
    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> (ADDR_W + 2)) == 32'd0);
    endfunction

    assign w_f_legal = addr_legal(f_req_addr);
    assign w_l_legal = addr_legal(l_req_addr);
    assign w_starved = (r_starve == CNT_MAX);

    // Fetch is blocked as soon as halt_req is seen, even before DRAIN is entered.
    // Gating with rst_n keeps every combinational output at 0 during reset.
    assign w_f_grant = rst_n && (r_state == S_RUN) && !halt_req && f_req_valid
                       && !(l_req_valid && w_starved);
    assign w_l_grant = rst_n && l_req_valid && !w_f_grant;

    assign f_req_ready = w_f_grant;
    assign l_req_ready = w_l_grant;

    assign mem_en    = (w_f_grant && w_f_legal) || (w_l_grant && w_l_legal);
    assign mem_we    = w_l_grant && w_l_legal && l_req_we;
    assign mem_addr  = w_f_grant ? f_req_addr[ADDR_W+1:2] :
                       w_l_grant ? l_req_addr[ADDR_W+1:2] : '0;
    assign mem_wdata = w_l_grant ? l_req_wdata : 32'd0;

    // Read data comes straight from the memory in the response cycle; errors
    // and write acknowledges return zero.
    assign f_rsp_valid = r_f_rsp_valid;
    assign f_rsp_err   = r_f_rsp_err;
    assign f_rsp_data  = r_f_rd ? mem_rdata : 32'd0;
    assign l_rsp_valid = r_l_rsp_valid;
    assign l_rsp_err   = r_l_rsp_err;
    assign l_rsp_data  = r_l_rd ? mem_rdata : 32'd0;
    assign halt_ack    = r_halt_ack;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (halt_req) w_state_nxt = S_DRAIN;
            // A fetch response in flight this cycle must finish before the loader owns memory.
            S_DRAIN:  if (!halt_req)          w_state_nxt = S_RUN;
                      else if (!r_f_rsp_valid) w_state_nxt = S_HALTED;
            S_HALTED: if (!halt_req) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_starve      <= '0;
            r_halt_ack    <= 1'b0;
            r_f_rsp_valid <= 1'b0;
            r_f_rsp_err   <= 1'b0;
            r_f_rd        <= 1'b0;
            r_l_rsp_valid <= 1'b0;
            r_l_rsp_err   <= 1'b0;
            r_l_rd        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_halt_ack <= (w_state_nxt == S_HALTED);

            if (r_state != S_RUN || w_l_grant)
                r_starve <= '0;
            else if (l_req_valid && !w_starved)
                r_starve <= r_starve + 1'b1;

            r_f_rsp_valid <= w_f_grant;
            r_f_rsp_err   <= w_f_grant && !w_f_legal;
            r_f_rd        <= w_f_grant && w_f_legal;
            r_l_rsp_valid <= w_l_grant;
            r_l_rsp_err   <= w_l_grant && !w_l_legal;
            r_l_rd        <= w_l_grant && w_l_legal && !l_req_we;
        end
    end

endmodule
